// File: rtl/sdram_arbiter_pkg.sv
// sdram_arbiter_pkg: shared state/owner encodings and default widths for the SDRAM arbiter.
package sdram_arb_pkg;
    localparam int REF_PERIOD_DEF = 780;
    localparam int ADDR_BITS      = 22;
    localparam int DATA_BITS      = 32;
    localparam int BURST_W        = 4;
    localparam int SIZE_W         = 2;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_e;
    typedef enum logic [1:0] {REF, C0, C1} owner_e;
endpackage

// File: rtl/sdram_arbiter_if.sv
// sdram_arbiter_if: client ports, controller command bus and status of the SDRAM arbiter.
interface sdram_arbiter_if #(
    parameter int ADDR_W = sdram_arb_pkg::ADDR_BITS,
    parameter int DATA_W = sdram_arb_pkg::DATA_BITS
);
    import sdram_arb_pkg::*;
    logic                req0, req1, wr0, wr1;
    logic [ADDR_W-1:0]   addr0, addr1;
    logic [DATA_W-1:0]   wdata0, wdata1;
    logic [BURST_W-1:0]  burst0, burst1;
    logic [SIZE_W-1:0]   size0, size1;
    logic                gnt0, gnt1, done0, done1;
    logic [DATA_W-1:0]   rdata;
    logic                ctl_start, ctl_refresh, ctl_write;
    logic [ADDR_W-1:0]   ctl_addr;
    logic [DATA_W-1:0]   ctl_wdata;
    logic [BURST_W-1:0]  ctl_burst;
    logic [SIZE_W-1:0]   ctl_size;
    logic                ctl_ready, ctl_done;
    logic [DATA_W-1:0]   ctl_rdata;
    logic                busy, ref_overrun;

    modport slave (
        input  req0, req1, wr0, wr1, addr0, addr1, wdata0, wdata1, burst0, burst1, size0, size1,
               ctl_ready, ctl_done, ctl_rdata,
        output gnt0, gnt1, done0, done1, rdata, ctl_start, ctl_refresh, ctl_write, ctl_addr,
               ctl_wdata, ctl_burst, ctl_size, busy, ref_overrun
    );
    modport master (
        output req0, req1, wr0, wr1, addr0, addr1, wdata0, wdata1, burst0, burst1, size0, size1,
               ctl_ready, ctl_done, ctl_rdata,
        input  gnt0, gnt1, done0, done1, rdata, ctl_start, ctl_refresh, ctl_write, ctl_addr,
               ctl_wdata, ctl_burst, ctl_size, busy, ref_overrun
    );
endinterface

// File: rtl/sdram_arbiter_refresh_timer.sv
// refresh_timer: periodic refresh request generator with a sticky overrun flag.
module refresh_timer
    import sdram_arb_pkg::*;
#(
    parameter int PERIOD = REF_PERIOD_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic ref_ack_i,
    output logic ref_pending_o,
    output logic ref_overrun_o
);
    localparam int CW = $clog2(PERIOD + 1);
    localparam logic [CW-1:0] RELOAD = CW'(PERIOD - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          pend_q, pend_d, ovr_q, ovr_d, tick;

    // A fresh tick wins over an acknowledge landing in the same cycle.
    always_comb begin
        tick   = cnt_q == '0;
        cnt_d  = tick ? RELOAD : cnt_q - 1'b1;
        pend_d = tick || (pend_q && !ref_ack_i);
        ovr_d  = ovr_q || (tick && pend_q && !ref_ack_i);
    end

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            cnt_q  <= RELOAD;
            pend_q <= 1'b0;
            ovr_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            pend_q <= pend_d;
            ovr_q  <= ovr_d;
        end

    assign ref_pending_o = pend_q;
    assign ref_overrun_o = ovr_q;
endmodule

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: round-robin two-client arbiter with prioritised auto-refresh in front of the
// SDRAM controller; one outstanding command at a time, completions routed to the owner.
module sdram_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int REF_PERIOD = REF_PERIOD_DEF,
    parameter int ADDR_W     = ADDR_BITS,
    parameter int DATA_W     = DATA_BITS
) (
    input logic          clk,
    input logic          reset,
    sdram_arbiter_if.slave bus
);
    state_e              state_q, state_d;
    owner_e              owner_q, owner_d;
    logic                last_q, last_d, write_q, write_d, done0_q, done0_d, done1_q, done1_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d, rdata_q, rdata_d;
    logic [BURST_W-1:0]  burst_q, burst_d;
    logic [SIZE_W-1:0]   size_q, size_d;
    logic                ref_pending, ref_ack, sel1, selr;

    refresh_timer #(.PERIOD(REF_PERIOD)) u_timer (
        .clk          (clk),
        .reset        (reset),
        .ref_ack_i    (ref_ack),
        .ref_pending_o(ref_pending),
        .ref_overrun_o(bus.ref_overrun)
    );

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        burst_d = burst_q;
        size_d  = size_q;
        rdata_d = rdata_q;
        done0_d = 1'b0;
        done1_d = 1'b0;
        ref_ack = 1'b0;
        sel1    = 1'b0;
        selr    = 1'b0;
        unique case (state_q)
            IDLE: if (bus.ctl_ready && (ref_pending || bus.req0 || bus.req1)) begin
                // last_q=1 means client 1 was served last, so client 0 wins a tie.
                owner_d = ref_pending ? REF : (bus.req0 && (!bus.req1 || last_q)) ? C0 : C1;
                selr    = owner_d == REF;
                sel1    = owner_d == C1;
                write_d = selr ? 1'b0 : sel1 ? bus.wr1    : bus.wr0;
                addr_d  = selr ? '0   : sel1 ? bus.addr1  : bus.addr0;
                wdata_d = selr ? '0   : sel1 ? bus.wdata1 : bus.wdata0;
                burst_d = selr ? '0   : sel1 ? bus.burst1 : bus.burst0;
                size_d  = selr ? '0   : sel1 ? bus.size1  : bus.size0;
                state_d = ISSUE;
            end
            ISSUE: begin
                ref_ack = owner_q == REF;
                last_d  = (owner_q == REF) ? last_q : owner_q == C1;
                state_d = WAIT;
            end
            WAIT: if (bus.ctl_done) begin
                done0_d = owner_q == C0;
                done1_d = owner_q == C1;
                rdata_d = (owner_q != REF && !write_q) ? bus.ctl_rdata : rdata_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state_q <= IDLE;
            owner_q <= REF;
            last_q  <= 1'b1;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            burst_q <= '0;
            size_q  <= '0;
            rdata_q <= '0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            burst_q <= burst_d;
            size_q  <= size_d;
            rdata_q <= rdata_d;
            done0_q <= done0_d;
            done1_q <= done1_d;
        end

    assign bus.ctl_start   = state_q == ISSUE;
    assign bus.ctl_refresh = bus.ctl_start && owner_q == REF;
    assign bus.gnt0        = bus.ctl_start && owner_q == C0;
    assign bus.gnt1        = bus.ctl_start && owner_q == C1;
    assign bus.done0       = done0_q;
    assign bus.done1       = done1_q;
    assign bus.rdata       = rdata_q;
    assign bus.ctl_write   = write_q;
    assign bus.ctl_addr    = addr_q;
    assign bus.ctl_wdata   = wdata_q;
    assign bus.ctl_burst   = burst_q;
    assign bus.ctl_size    = size_q;
    assign bus.busy        = state_q != IDLE;
endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter: directed vectors, refresh/reset corner sequences and a randomized run
// checked against a transaction-phase reference model of the arbiter.
module tb_sdram_arbiter;
    import sdram_arb_pkg::*;
    localparam int P = 16;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    sdram_arbiter_if bus ();
    sdram_arbiter #(.REF_PERIOD(P)) dut (.clk(clk), .reset(reset), .bus(bus));

    int errors = 0, checks = 0, e = 0;

    typedef struct {
        bit          port;
        bit          wr;
        logic [21:0] addr;
        logic [31:0] wdata;
        logic [3:0]  burst;
        logic [1:0]  size;
        logic [31:0] ret;
        int          dly;
        logic [31:0] exp_rdata;
    } vec_t;
    vec_t vt[4];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, e);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        e++;
    endtask

    task automatic drive_client(input bit p, input bit rq, input bit wr, input logic [21:0] a,
                                input logic [31:0] wd, input logic [3:0] b, input logic [1:0] s);
        if (p) begin
            bus.req1 = rq; bus.wr1 = wr; bus.addr1 = a; bus.wdata1 = wd; bus.burst1 = b; bus.size1 = s;
        end else begin
            bus.req0 = rq; bus.wr0 = wr; bus.addr0 = a; bus.wdata0 = wd; bus.burst0 = b; bus.size0 = s;
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        drive_client(0, 0, 0, '0, '0, '0, '0);
        drive_client(1, 0, 0, '0, '0, '0, '0);
        bus.ctl_ready = 0; bus.ctl_done = 0; bus.ctl_rdata = '0;
        step();
        step();
        reset = 1'b1;
        e = 0;
    endtask

    task automatic wait_start(input string name);
        for (int i = 0; i < 40 && !bus.ctl_start; i++) step();
        chk({name, "_start"}, bus.ctl_start, 1);
    endtask

    // Random-run model state: phase 0 idle, 1 command issued this cycle, 2 awaiting completion.
    bit          r[2];
    logic        cwr[2];
    logic [21:0] caddr[2];
    logic [31:0] cwd[2];
    logic [3:0]  cb[2];
    logic [1:0]  cs[2];
    int          ph, own, last_c, cd, nstart;
    bit          pend_m, ovr_m, tick, ack, n_d0, n_d1, rdy, dn, e_wr;
    logic [31:0] rd_m, crd, e_wd;
    logic [21:0] e_addr;
    logic [3:0]  e_b;
    logic [1:0]  e_s;
    int          starts[$];
    bit          gq[$];

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vt[0] = '{0, 0, 22'h012C05, 32'h0,         4'h1, 2'h2, 32'hDEADBEEF, 1, 32'hDEADBEEF};
        vt[1] = '{1, 1, 22'h3FFFFF, 32'hA5A55A5A,  4'hF, 2'h3, 32'h12345678, 3, 32'h0};
        vt[2] = '{1, 0, 22'h000000, 32'h0,         4'h0, 2'h0, 32'hFFFFFFFF, 2, 32'hFFFFFFFF};
        vt[3] = '{0, 1, 22'h2ABCDE, 32'hCAFEF00D,  4'h8, 2'h1, 32'h0BAD0BAD, 4, 32'h0};

        for (int i = 0; i < 4; i++) begin
            do_reset();
            chk("reset_outs", {bus.busy, bus.ctl_start, bus.ctl_refresh, bus.gnt0, bus.gnt1,
                               bus.done0, bus.done1, bus.ref_overrun, bus.ctl_write}, 0);
            chk("reset_rdata", bus.rdata, 0);
            bus.ctl_ready = 1;
            drive_client(vt[i].port, 1, vt[i].wr, vt[i].addr, vt[i].wdata, vt[i].burst, vt[i].size);
            step();
            chk("vec_gnt", {bus.gnt1, bus.gnt0}, vt[i].port ? 2'b10 : 2'b01);
            chk("vec_start", {bus.ctl_start, bus.ctl_refresh}, 2'b10);
            chk("vec_fields", {bus.ctl_write, bus.ctl_addr, bus.ctl_burst, bus.ctl_size},
                {vt[i].wr, vt[i].addr, vt[i].burst, vt[i].size});
            chk("vec_wdata", bus.ctl_wdata, vt[i].wdata);
            drive_client(vt[i].port, 0, 0, '0, '0, '0, '0);
            repeat (vt[i].dly) step();
            chk("vec_wait_busy", {bus.busy, bus.ctl_start}, 2'b10);
            bus.ctl_done = 1; bus.ctl_rdata = vt[i].ret;
            step();
            bus.ctl_done = 0;
            chk("vec_done", {bus.done1, bus.done0}, vt[i].port ? 2'b10 : 2'b01);
            chk("vec_rdata", bus.rdata, vt[i].exp_rdata);
            chk("vec_held_addr", bus.ctl_addr, vt[i].addr);
            chk("vec_idle", bus.busy, 0);
            step();
            chk("vec_done_pulse", {bus.done1, bus.done0}, 0);
        end

        // Refresh alone: ticks at edges 16,32,.. so commands appear at edges 17,33,49,65.
        do_reset();
        bus.ctl_ready = 1;
        cd = 0; nstart = 0;
        starts.delete();
        repeat (70) begin
            bus.ctl_done = 0;
            if (cd > 0) begin cd--; bus.ctl_done = cd == 0; end
            step();
            if (bus.ctl_start) begin
                cd = 2;
                starts.push_back(e);
                chk("ref_flag", bus.ctl_refresh, 1);
            end
            if (bus.gnt0 || bus.gnt1 || bus.done0 || bus.done1) nstart++;
        end
        chk("ref_count", starts.size(), 4);
        for (int i = 0; i < starts.size(); i++) chk("ref_at", starts[i], 17 + P * i);
        chk("ref_no_client", nstart, 0);

        // Both clients requesting continuously: grants must alternate starting with client 0.
        do_reset();
        bus.ctl_ready = 1;
        bus.req0 = 1; bus.req1 = 1;
        cd = 0;
        gq.delete();
        repeat (60) begin
            bus.ctl_done = 0;
            if (cd > 0) begin cd--; bus.ctl_done = cd == 0; end
            step();
            if (bus.ctl_start) cd = 3;
            if (bus.gnt0) gq.push_back(0);
            if (bus.gnt1) gq.push_back(1);
        end
        chk("rr_count", gq.size() >= 6, 1);
        if (gq.size() > 0) chk("rr_first", gq[0], 0);
        for (int i = 1; i < gq.size(); i++) chk("rr_alt", gq[i], !gq[i-1]);
        bus.req0 = 0; bus.req1 = 0;

        // Tick during a client-0 wait with client 1 queued: refresh goes first, then client 1.
        do_reset();
        bus.ctl_ready = 1;
        repeat (10) step();
        drive_client(0, 1, 0, 22'h00ABC, 0, 1, 1);
        wait_start("b_c0");
        chk("b_c0_gnt", {bus.gnt0, bus.ctl_refresh}, 2'b10);
        drive_client(0, 0, 0, '0, '0, '0, '0);
        drive_client(1, 1, 1, 22'h1F00F, 32'h55AA55AA, 2, 2);
        while (e < 19) step();
        bus.ctl_done = 1;
        step();
        bus.ctl_done = 0;
        chk("b_done0", bus.done0, 1);
        wait_start("b_ref");
        chk("b_ref_first", {bus.ctl_refresh, bus.gnt1}, 2'b10);
        step();
        bus.ctl_done = 1;
        step();
        bus.ctl_done = 0;
        wait_start("b_c1");
        chk("b_c1_after", {bus.gnt1, bus.ctl_refresh}, 2'b10);
        chk("b_c1_addr", bus.ctl_addr, 22'h1F00F);

        // Controller never ready across two ticks: overrun latches and stays set.
        do_reset();
        repeat (20) step();
        chk("ovr_one_tick", {bus.ref_overrun, bus.busy}, 0);
        repeat (14) step();
        chk("ovr_two_ticks", bus.ref_overrun, 1);
        bus.ctl_ready = 1;
        repeat (10) step();
        chk("ovr_sticky", bus.ref_overrun, 1);

        // Asynchronous reset mid-wait drops everything at once and forgets the transaction.
        do_reset();
        chk("d_ovr_cleared", bus.ref_overrun, 0);
        bus.ctl_ready = 1;
        drive_client(0, 1, 0, 22'h12C05, 0, 3, 1);
        step();
        drive_client(0, 0, 0, '0, '0, '0, '0);
        step();
        chk("d_in_wait", bus.busy, 1);
        reset = 0;
        #1;
        chk("d_async_outs", {bus.busy, bus.ctl_start, bus.gnt0, bus.done0, bus.ctl_burst}, 0);
        chk("d_async_addr", bus.ctl_addr, 0);
        step();
        step();
        reset = 1; e = 0;
        bus.ctl_done = 1; bus.ctl_rdata = 32'h77777777;
        step();
        bus.ctl_done = 0;
        chk("d_no_done", {bus.done0, bus.done1, bus.busy}, 0);
        chk("d_rdata_kept", bus.rdata, 0);
        while (e < 17) step();
        chk("d_ref_restart", {bus.ctl_start, bus.ctl_refresh}, 2'b11);

        // Randomized traffic against the phase model.
        do_reset();
        r[0] = 0; r[1] = 0; cd = 0;
        ph = 0; own = 0; last_c = 1; pend_m = 0; ovr_m = 0; rd_m = '0;
        e_wr = 0; e_addr = '0; e_wd = '0; e_b = '0; e_s = '0;
        repeat (800) begin
            for (int i = 0; i < 2; i++)
                if (!r[i] && $urandom_range(0, 2) == 0) begin
                    r[i] = 1; cwr[i] = 1'($urandom); caddr[i] = 22'($urandom); cwd[i] = $urandom;
                    cb[i] = 4'($urandom); cs[i] = 2'($urandom);
                end else if (r[i] && $urandom_range(0, 24) == 0) r[i] = 0;
            for (int i = 0; i < 2; i++) drive_client(i[0], r[i], cwr[i], caddr[i], cwd[i], cb[i], cs[i]);
            rdy = $urandom_range(0, 4) != 0;
            dn = 0;
            if (cd > 0) begin cd--; dn = cd == 0; end
            crd = $urandom;
            bus.ctl_ready = rdy; bus.ctl_done = dn; bus.ctl_rdata = crd;
            tick = ((e + 1) % P) == 0;
            ack = ph == 1 && own == 2;
            n_d0 = 0; n_d1 = 0;
            if (ph == 0 && rdy && (pend_m || r[0] || r[1])) begin
                own = pend_m ? 2 : (r[0] && r[1]) ? 1 - last_c : (r[0] ? 0 : 1);
                e_wr   = own == 2 ? 1'b0 : cwr[own];
                e_addr = own == 2 ? '0 : caddr[own];
                e_wd   = own == 2 ? '0 : cwd[own];
                e_b    = own == 2 ? '0 : cb[own];
                e_s    = own == 2 ? '0 : cs[own];
                ph = 1;
            end else if (ph == 1) begin
                if (own != 2) last_c = own;
                ph = 2;
            end else if (ph == 2 && dn) begin
                n_d0 = own == 0; n_d1 = own == 1;
                if (own != 2 && !e_wr) rd_m = crd;
                ph = 0;
            end
            ovr_m = ovr_m || (tick && pend_m && !ack);
            pend_m = tick || (pend_m && !ack);
            step();
            chk("rand_ctrl", {bus.gnt0, bus.gnt1, bus.ctl_start, bus.ctl_refresh, bus.done0,
                              bus.done1, bus.busy, bus.ref_overrun},
                {(ph == 1 && own == 0), (ph == 1 && own == 1), (ph == 1), (ph == 1 && own == 2),
                 n_d0, n_d1, (ph != 0), ovr_m});
            chk("rand_rdata", bus.rdata, rd_m);
            if (ph == 1) begin
                chk("rand_fields", {bus.ctl_write, bus.ctl_addr, bus.ctl_burst, bus.ctl_size},
                    {e_wr, e_addr, e_b, e_s});
                chk("rand_wdata", bus.ctl_wdata, e_wd);
            end
            if (bus.ctl_start) cd = $urandom_range(1, 4);
            if (bus.gnt0) r[0] = 0;
            if (bus.gnt1) r[1] = 0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sdram_arbiter.md
# sdram_arbiter

Two-port request arbiter and refresh scheduler sitting in front of the SDRAM control unit. It accepts read/write transactions from two client ports, round-robins between them, and injects periodic auto-refresh commands at higher priority. It issues exactly one transaction at a time to the controller and routes completion and read data back to the originating client.

## Interface
Parameters:
- REF_PERIOD, 780: cycles between refresh requests.
- ADDR_W, 22: transaction address width (bank 21:20, row 19:10, col 9:0).
- DATA_W, 32: data width.

Ports:
- clk  in  1  single clock; all state on rising edge.
- reset  in  1  asynchronous, active-low; low forces the reset state immediately.
- req0 / req1  in  1  client request, held high until gnt.
- wr0 / wr1  in  1  1 = write, 0 = read.
- addr0 / addr1  in  ADDR_W  transaction address.
- wdata0 / wdata1  in  DATA_W  write data.
- burst0 / burst1  in  4  burst length code.
- size0 / size1  in  2  transfer size code.
- gnt0 / gnt1  out  1  one-cycle pulse: request accepted, fields latched.
- done0 / done1  out  1  one-cycle pulse: transaction complete.
- rdata  out  DATA_W  read data, valid with done pulse of a read.
- ctl_start  out  1  one-cycle command strobe to controller.
- ctl_refresh  out  1  qualifies ctl_start as refresh.
- ctl_write, ctl_addr, ctl_wdata, ctl_burst, ctl_size  out  —  latched command fields, stable from ctl_start until ctl_done.
- ctl_ready  in  1  controller idle and able to accept ctl_start.
- ctl_done  in  1  one-cycle completion pulse from controller.
- ctl_rdata  in  DATA_W  read data, valid with ctl_done.
- busy  out  1  high in any state except IDLE.
- ref_overrun  out  1  sticky: refresh tick arrived while one was still pending.

## Operation
- States: IDLE, ISSUE, WAIT. ISSUE lasts exactly one cycle.
- IDLE: if ctl_ready=1, select in priority order: ref_pending, then clients by round-robin. No selection → stay IDLE.
- Round-robin: pointer last holds last granted client; with both req high, grant the other one. Single request granted regardless of pointer. Reset value of last = 1 (client 0 wins first contention).
- On selection (IDLE→ISSUE edge): latch owner (REF, C0, C1) and command fields; refresh drives ctl_write=0, other fields 0.
- ISSUE: ctl_start=1, ctl_refresh=(owner==REF), gnt_owner=1 for client owners; update last; clear ref_pending if owner REF. → WAIT.
- WAIT: hold fields; on ctl_done → register ctl_rdata into rdata, assert done_owner next cycle (none for REF), → IDLE.
- Refresh timer: down-counter reloads REF_PERIOD-1, ticks at 0. Tick sets ref_pending; tick while ref_pending=1 sets ref_overrun.
- ctl_done outside WAIT ignored. req dropped before gnt: silently withdrawn.
- rdata holds last value between completions; write completions leave rdata unchanged.

## Timing
- Reset values: all outputs 0, state IDLE, counter REF_PERIOD-1, ref_pending 0, last 1, rdata 0.
- req sampled high at edge N in IDLE with ctl_ready=1 → ctl_start and gnt high in cycle N+1.
- ctl_done at cycle M → done and rdata valid cycle M+1; state IDLE in M+1, new ISSUE earliest M+2.
- Refresh tick in WAIT is served at the next IDLE ahead of pending clients.
- Simultaneous tick and selection in IDLE: the tick's ref_pending is seen next IDLE, not this one.
- Reset mid-transaction: abandons it, no done pulse, counter restarts.

## Structure
- Package sdram_arb_pkg: state enum (IDLE, ISSUE, WAIT), owner enum (REF, C0, C1), default REF_PERIOD, field widths.
- Sub-module refresh_timer: counter, ref_pending, ref_overrun; input ref_ack from the arbiter FSM.

## Test plan
- Single read on port 0, addr 0x12C05, ctl_ready=1 → gnt0 and ctl_start next cycle, ctl_addr=0x12C05; ctl_done with ctl_rdata 0xDEADBEEF → done0, rdata=0xDEADBEEF next cycle.
- req0 and req1 held high continuously, ctl_done 3 cycles after each start → grants alternate 0,1,0,1; no port starves.
- REF_PERIOD=16, no requests → ctl_start with ctl_refresh=1 every 16 cycles while controller idle; no gnt/done pulses.
- Refresh tick during client WAIT with req1 pending → next issue is refresh, then client 1.
- ctl_ready held 0 across two ticks → ref_overrun=1, stays set until reset.
- reset low during WAIT → outputs 0 immediately; later ctl_done produces no done pulse.
